// File: rtl/bcd_conv_arbiter_pkg.sv
// Shared types and constants for the two-requester binary-to-BCD converter.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package bcd_conv_arbiter_pkg;

   // Default geometry: 20-bit operand, six BCD digits, saturate above 999999.
   localparam int DEF_N       = 20;
   localparam int DEF_DIGITS  = 6;
   localparam int DEF_BCD_MAX = 999999;

   // Owner / grant encoding shared by the arbiter and bcd_owner.
   localparam logic OWNER_A = 1'b0;
   localparam logic OWNER_B = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Round-robin pick: a lone requester wins; on a tie the requester that
   // was not granted last time wins.
   function automatic logic pick_winner(input logic ra,
                                        input logic rb,
                                        input logic last_grant);
      logic w;
      if (ra && rb) begin
         w = ~last_grant;
      end else if (rb) begin
         w = OWNER_B;
      end else begin
         w = OWNER_A;
      end
      return w;
   endfunction

endpackage

// File: rtl/bcd_conv_arbiter_dd_step.sv
// One double-dabble iteration: add 3 to every digit >= 5, then shift left one bit.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle, the caller decides when to register.
// Ports:
//   digits     in  4*DIGITS  current BCD digit register, units in [3:0]
//   in_bit     in  1         next operand bit, enters the units LSB
//   digits_nxt out 4*DIGITS  digits after adjust and shift
module bcd_conv_arbiter_dd_step #(
   parameter int DIGITS = 6
) (
   input  logic [4*DIGITS-1:0] digits,
   input  logic                in_bit,
   output logic [4*DIGITS-1:0] digits_nxt
);

   logic [4*DIGITS-1:0] adj;
   logic                dropped_unused;

   // Per-digit correction is strictly 4-bit; any carry out of a nibble is
   // discarded, which cannot happen for legal BCD digits (max 9+3=12).
   always_comb begin
      adj = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (digits[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = digits[4*i +: 4] + 4'd3;
         end else begin
            adj[4*i +: 4] = digits[4*i +: 4];
         end
      end
   end

   // The bit shifted out of the top digit is lost; inputs above the
   // representable range are caught by the saturation flag instead.
   assign {dropped_unused, digits_nxt} = {adj, in_bit};

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Shared shift/add-3 binary-to-BCD converter with a two-way round-robin arbiter.
// Latency: ack the cycle after the grant edge, bcd_valid N+1 cycles after the grant edge.
// Backpressure: level requests wait while busy; one conversion per N+2 cycles.
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   req_a/bin_a         requester A level request and operand (sampled on grant edge)
//   req_b/bin_b         requester B level request and operand (sampled on grant edge)
//   ack_a/ack_b         one-cycle pulse: that requester's operand was captured
//   busy                high while a conversion is in flight
//   bcd_out             last result, hundred-thousands digit on top, units in [3:0]
//   bcd_owner           requester that owns bcd_out (0=A, 1=B)
//   bcd_valid           one-cycle pulse: bcd_out/bcd_owner/overflow just updated
//   overflow            last result was saturated to all nines
module bcd_conv_arbiter
   import bcd_conv_arbiter_pkg::*;
#(
   parameter int N       = DEF_N,
   parameter int DIGITS  = DEF_DIGITS,
   parameter int BCD_MAX = DEF_BCD_MAX
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_a,
   input  logic [N-1:0]        bin_a,
   input  logic                req_b,
   input  logic [N-1:0]        bin_b,
   output logic                ack_a,
   output logic                ack_b,
   output logic                busy,
   output logic [4*DIGITS-1:0] bcd_out,
   output logic                bcd_owner,
   output logic                bcd_valid,
   output logic                overflow
);

   localparam int                CNT_W   = (N > 1) ? $clog2(N) : 1;
   localparam int                BCD_W   = 4 * DIGITS;
   localparam logic [N-1:0]      MAX_W   = N'(BCD_MAX);
   localparam logic [BCD_W-1:0]  SAT_BCD = {DIGITS{4'h9}};
   localparam logic [CNT_W-1:0]  CNT_TOP = CNT_W'(N - 1);

   state_t             state_q;
   state_t             state_nxt;
   logic [N-1:0]       op_q;
   logic [BCD_W-1:0]   dig_q;
   logic [BCD_W-1:0]   dig_step;
   logic [CNT_W-1:0]   cnt_q;
   logic               ovf_q;
   logic               last_grant_q;

   logic               any_req;
   logic               grant_fire;
   logic               winner;
   logic [N-1:0]       grant_bin;

   assign any_req    = req_a | req_b;
   assign grant_fire = (state_q == ST_IDLE) && any_req;
   assign winner     = pick_winner(req_a, req_b, last_grant_q);
   assign grant_bin  = (winner == OWNER_B) ? bin_b : bin_a;
   assign busy       = (state_q != ST_IDLE);

   bcd_conv_arbiter_dd_step #(
      .DIGITS (DIGITS)
   ) u_dd_step (
      .digits     (dig_q),
      .in_bit     (op_q[N-1]),
      .digits_nxt (dig_step)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         ST_IDLE:  if (any_req) state_nxt = ST_SHIFT;
         ST_SHIFT: if (cnt_q == '0) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q         <= '0;
         dig_q        <= '0;
         cnt_q        <= '0;
         ovf_q        <= 1'b0;
         last_grant_q <= OWNER_B;   // so A wins the first tie
         ack_a        <= 1'b0;
         ack_b        <= 1'b0;
         bcd_out      <= '0;
         bcd_owner    <= OWNER_A;
         bcd_valid    <= 1'b0;
         overflow     <= 1'b0;
      end else begin
         ack_a     <= 1'b0;
         ack_b     <= 1'b0;
         bcd_valid <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (grant_fire) begin
                  op_q         <= grant_bin;
                  dig_q        <= '0;
                  cnt_q        <= CNT_TOP;
                  // Range check is done once on the captured operand so the
                  // shift loop never needs to look at it again.
                  ovf_q        <= (grant_bin > MAX_W);
                  last_grant_q <= winner;
                  ack_a        <= (winner == OWNER_A);
                  ack_b        <= (winner == OWNER_B);
               end
            end
            ST_SHIFT: begin
               dig_q <= dig_step;
               op_q  <= {op_q[N-2:0], 1'b0};
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            ST_DONE: begin
               bcd_out   <= ovf_q ? SAT_BCD : dig_q;
               bcd_owner <= last_grant_q;
               overflow  <= ovf_q;
               bcd_valid <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed bench for bcd_conv_arbiter with a timeline reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_bcd_conv_arbiter;

   localparam int N = 20;

   logic          clk   = 1'b0;
   logic          rst   = 1'b1;
   logic          req_a = 1'b0;
   logic          req_b = 1'b0;
   logic [N-1:0]  bin_a = '0;
   logic [N-1:0]  bin_b = '0;
   logic          ack_a, ack_b, busy, bcd_valid, bcd_owner, overflow;
   logic [23:0]   bcd_out;

   int checks = 0;
   int errors = 0;
   int ncyc   = 0;

   bcd_conv_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .req_a     (req_a),
      .bin_a     (bin_a),
      .req_b     (req_b),
      .bin_b     (bin_b),
      .ack_a     (ack_a),
      .ack_b     (ack_b),
      .busy      (busy),
      .bcd_out   (bcd_out),
      .bcd_owner (bcd_owner),
      .bcd_valid (bcd_valid),
      .overflow  (overflow)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) ncyc++;

   // ---------------- reference model ----------------
   // Decimal conversion by plain division, saturating above 999999.
   function automatic logic [23:0] bcd_of(input int v);
      logic [23:0] r = '0;
      int x = v;
      if (v > 999999) return 24'h999999;
      for (int i = 0; i < 6; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   // Timeline: a grant at edge g gives ack in cycle g, busy in g..g+N,
   // the result in cycle g+N+1, and the next grant no earlier than edge g+N+2.
   int          edge_n    = 0;
   int          g         = -100;
   logic        g_owner   = 1'b0;
   logic        g_ovf     = 1'b0;
   logic [23:0] g_bcd     = '0;
   logic        m_last    = 1'b1;
   logic [23:0] exp_bcd   = '0;
   logic        exp_owner = 1'b0;
   logic        exp_ovf   = 1'b0;

   always @(posedge clk or posedge rst) begin
      int val;
      if (rst) begin
         g         = -100;
         m_last    = 1'b1;
         exp_bcd   = '0;
         exp_owner = 1'b0;
         exp_ovf   = 1'b0;
      end else begin
         edge_n++;
         if (edge_n == g + N + 1) begin
            exp_bcd   = g_bcd;
            exp_owner = g_owner;
            exp_ovf   = g_ovf;
         end
         if ((edge_n >= g + N + 2) && (req_a || req_b)) begin
            g_owner = (req_a && req_b) ? ~m_last : req_b;
            m_last  = g_owner;
            g       = edge_n;
            val     = g_owner ? int'(bin_b) : int'(bin_a);
            g_bcd   = bcd_of(val);
            g_ovf   = (val > 999999);
         end
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      logic [29:0] act_v;
      logic [29:0] exp_v;
      logic e_ack_a, e_ack_b, e_busy, e_valid;
      e_ack_a = (edge_n == g) && !g_owner && !rst;
      e_ack_b = (edge_n == g) &&  g_owner && !rst;
      e_busy  = (edge_n >= g) && (edge_n <= g + N) && !rst;
      e_valid = (edge_n == g + N + 1) && !rst;
      act_v = {ack_a, ack_b, busy, bcd_valid, bcd_owner, overflow, bcd_out};
      exp_v = {e_ack_a, e_ack_b, e_busy, e_valid, exp_owner, exp_ovf, exp_bcd};
      checks++;
      if (act_v !== exp_v) begin
         errors++;
         $display("FAIL model_cycle %0d: got ack_a/ack_b/busy/valid/owner/ovf/bcd=%b%b%b%b%b%b/%h expected %b%b%b%b%b%b/%h",
                  ncyc, act_v[29], act_v[28], act_v[27], act_v[26], act_v[25], act_v[24], act_v[23:0],
                  exp_v[29], exp_v[28], exp_v[27], exp_v[26], exp_v[25], exp_v[24], exp_v[23:0]);
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_valid(output int tv);
      bit ok = 1'b0;
      tv = 0;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge clk);
         if (bcd_valid) begin
            ok = 1'b1;
            tv = ncyc;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL valid_timeout: got no bcd_valid expected one within 60 cycles");
      end
   endtask

   task automatic req_a_task(input logic [N-1:0] v, output int t);
      bit seen = 1'b0;
      t = 0;
      req_a = 1'b1;
      bin_a = v;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (ack_a) begin
            seen = 1'b1;
            t = ncyc;
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL ack_a_timeout: got no ack_a expected one within 100 cycles");
      end
      @(posedge clk);
      #1 req_a = 1'b0;
   endtask

   task automatic req_b_task(input logic [N-1:0] v, output int t);
      bit seen = 1'b0;
      t = 0;
      req_b = 1'b1;
      bin_b = v;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (ack_b) begin
            seen = 1'b1;
            t = ncyc;
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL ack_b_timeout: got no ack_b expected one within 100 cycles");
      end
      @(posedge clk);
      #1 req_b = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got no finish expected finish before 300000 time units");
      $fatal(1, "watchdog");
   end

   // ---------------- directed tests ----------------
   initial begin
      int          ta, tb_, tv, tv2, tv_prev, nev;
      int          t2_val [3];
      logic [23:0] t2_bcd [3];
      logic        t2_ovf [3];
      logic        t4_own [4];
      logic [23:0] t4_bcd [4];

      t2_val = '{0, 999999, 1048575};
      t2_bcd = '{24'h000000, 24'h999999, 24'h999999};
      t2_ovf = '{1'b0, 1'b0, 1'b1};
      t4_own = '{1'b0, 1'b1, 1'b0, 1'b1};
      t4_bcd = '{24'h000011, 24'h000222, 24'h000011, 24'h000222};

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_busy",    32'(busy), 32'd0);
      chk("reset_bcd_out", 32'(bcd_out), 32'd0);
      chk("reset_valid",   32'(bcd_valid), 32'd0);
      chk("reset_ack",     32'({ack_a, ack_b}), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // 1: basic conversion and latency
      req_a_task(20'd123456, ta);
      wait_valid(tv);
      chk("t1_latency", 32'(tv - ta), 32'd21);
      chk("t1_bcd",     32'(bcd_out), 32'h123456);
      chk("t1_owner",   32'(bcd_owner), 32'd0);
      chk("t1_ovf",     32'(overflow), 32'd0);

      // 2: boundaries and saturation
      for (int k = 0; k < 3; k++) begin
         req_a_task(N'(t2_val[k]), ta);
         wait_valid(tv);
         chk("t2_bcd", 32'(bcd_out), 32'(t2_bcd[k]));
         chk("t2_ovf", 32'(overflow), 32'(t2_ovf[k]));
      end

      // 3: simultaneous requests after reset -> A first, B next
      @(posedge clk);
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      fork
         req_a_task(20'd42, ta);
         req_b_task(20'd7, tb_);
         begin
            wait_valid(tv);
            chk("t3_first_bcd",    32'(bcd_out), 32'h000042);
            chk("t3_first_owner",  32'(bcd_owner), 32'd0);
            wait_valid(tv2);
            chk("t3_second_bcd",   32'(bcd_out), 32'h000007);
            chk("t3_second_owner", 32'(bcd_owner), 32'd1);
            chk("t3_spacing",      32'(tv2 - tv), 32'd22);
         end
      join

      // 4: both held -> strict alternation A,B,A,B at 22-cycle spacing
      bin_a = 20'd11;
      bin_b = 20'd222;
      req_a = 1'b1;
      req_b = 1'b1;
      tv_prev = 0;
      for (int k = 0; k < 4; k++) begin
         wait_valid(tv);
         chk("t4_owner", 32'(bcd_owner), 32'(t4_own[k]));
         chk("t4_bcd",   32'(bcd_out), 32'(t4_bcd[k]));
         if (k > 0) chk("t4_spacing", 32'(tv - tv_prev), 32'd22);
         tv_prev = tv;
      end
      req_a = 1'b0;
      req_b = 1'b0;

      // 5: reset in the middle of SHIFT
      req_a_task(20'd777777, ta);
      repeat (9) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("t5_busy",    32'(busy), 32'd0);
      chk("t5_bcd_out", 32'(bcd_out), 32'd0);
      nev = 0;
      for (int i = 0; i < 28; i++) begin
         if (i == 3) begin
            @(posedge clk);
            #1 rst = 1'b0;
         end
         @(negedge clk);
         if (bcd_valid || ack_a || ack_b) nev++;
      end
      chk("t5_no_events", 32'(nev), 32'd0);
      req_a_task(20'd500, ta);
      wait_valid(tv);
      chk("t5_rerequest_bcd", 32'(bcd_out), 32'h000500);

      // 6: B pulses while A converts and drops before DONE
      fork
         req_a_task(20'd321, ta);
         begin
            repeat (5) @(posedge clk);
            #1 req_b = 1'b1;
            bin_b = 20'd999;
            repeat (5) @(posedge clk);
            #1 req_b = 1'b0;
         end
         begin
            wait_valid(tv);
            chk("t6_bcd",   32'(bcd_out), 32'h000321);
            chk("t6_owner", 32'(bcd_owner), 32'd0);
         end
      join
      nev = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (ack_b || busy || bcd_valid) nev++;
      end
      chk("t6_idle_after", 32'(nev), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
